nec_operand_fetch: RTL

NEC_OPERAND_FETCH -- requirements
Module: nec_operand_fetch

---
 rtl/nec_operand_fetch.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/nec_operand_fetch.sv
// nec_operand_fetch
//   Walks the instruction prefetch queue one instruction at a time and builds
//   a decoded record:
//     - prefixes
//     - opcode
//     - ModRM
//     - displacement
//     - immediate
//   Byte classification (prefix / has ModRM / immediate size) is done by an
//   external combinational classifier that looks at cls_byte in the same cycle.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   ce_1, ce_2            : clock enables; bytes are consumed on ce_1 only
//   set_pc, new_pc        : redirect (takes effect with ce_1 or ce_2)
//   ipq, ipq_len          : queue bytes; the byte for address A sits at
//                           ipq[A mod QUEUE_DEPTH]. ipq_len is the number of
//                           bytes available from pc.
//   cls_byte              : byte at pc, offered to the classifier
//   cls_is_prefix, cls_has_modrm, cls_imm_size : classifier answers
//   retire_op             : consumer accepts the completed record
//   pc, valid             : next byte address, record complete
//   start_pc .. imm       : record outputs
module nec_operand_fetch #(
    parameter int QUEUE_DEPTH     = 8,
    parameter int BYTES_PER_CYCLE = 2,
    parameter int MAX_PREFIX      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce_1,
    input  logic                         ce_2,
    input  logic                         set_pc,
    input  logic [15:0]                  new_pc,
    input  logic [QUEUE_DEPTH-1:0][7:0]  ipq,
    input  logic [$clog2(QUEUE_DEPTH):0] ipq_len,
    output logic [7:0]                   cls_byte,
    input  logic                         cls_is_prefix,
    input  logic                         cls_has_modrm,
    input  logic [2:0]                   cls_imm_size,
    input  logic                         retire_op,
    output logic [15:0]                  pc,
    output logic                         valid,
    output logic [15:0]                  start_pc,
    output logic [15:0]                  end_pc,
    output logic [3:0]                   length,
    output logic [3:0]                   prefix_count,
    output logic [MAX_PREFIX-1:0][7:0]   prefixes,
    output logic                         prefix_ovf,
    output logic [7:0]                   opcode,
    output logic [7:0]                   modrm,
    output logic [15:0]                  disp,
    output logic [31:0]                  imm
);

    localparam int QW = $clog2(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_OPCODE   = 2'd0,
        ST_MODRM    = 2'd1,
        ST_OPERANDS = 2'd2,
        ST_TERMINAL = 2'd3
    } state_t;

    // Everything that is cleared when a new instruction starts.
    typedef struct packed {
        logic [MAX_PREFIX-1:0][7:0] prefixes;
        logic [3:0]                 prefix_count;
        logic                       prefix_ovf;
        logic [7:0]                 opcode;
        logic [7:0]                 modrm;
        logic [15:0]                disp;
        logic [31:0]                imm;
        logic [1:0]                 disp_sz;
        logic [2:0]                 imm_sz;
        logic [2:0]                 opnd_cnt;   // disp+imm bytes taken so far
    } rec_t;

    state_t      state_q, state_n;
    logic [15:0] pc_q, pc_n;
    logic [15:0] start_q, start_n;
    logic [15:0] end_q, end_n;
    rec_t        rec_q, rec_n;

    logic [7:0]  byte0;
    logic [2:0]  imm_sz_in;
    logic [4:0]  avail;
    logic        take_op;
    logic [1:0]  dsz;
    logic [4:0]  rem;
    logic [4:0]  n;
    logic [3:0]  bidx;
    logic [1:0]  iidx;
    logic [15:0] qaddr;
    logic [7:0]  qbyte;

    function automatic logic [1:0] disp_size(input logic [7:0] m);
        case (m[7:6])
            2'b00:   return (m[2:0] == 3'b110) ? 2'd2 : 2'd0;
            2'b01:   return 2'd1;
            2'b10:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    assign byte0     = ipq[pc_q[QW-1:0]];
    assign cls_byte  = byte0;
    // Only 0/1/2/4 are meaningful; anything larger is clamped to the imm width.
    assign imm_sz_in = (cls_imm_size > 3'd4) ? 3'd4 : cls_imm_size;
    assign avail     = 5'(ipq_len);

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        start_n = start_q;
        end_n   = end_q;
        rec_n   = rec_q;
        take_op = 1'b0;
        dsz     = 2'd0;
        rem     = 5'd0;
        n       = 5'd0;
        bidx    = 4'd0;
        iidx    = 2'd0;
        qaddr   = 16'd0;
        qbyte   = 8'd0;

        if (set_pc && (ce_1 || ce_2)) begin
            state_n = ST_OPCODE;
            pc_n    = new_pc;
            start_n = new_pc;
            end_n   = new_pc;
            rec_n   = '0;
        end else if (ce_1) begin
            unique case (state_q)
                ST_TERMINAL: begin
                    if (retire_op) begin
                        // Start the next record and fall into opcode handling
                        // below so its first byte costs no extra cycle.
                        rec_n   = '0;
                        start_n = pc_q;
                        state_n = ST_OPCODE;
                        take_op = 1'b1;
                    end
                end
                ST_OPCODE: take_op = 1'b1;
                ST_MODRM: begin
                    if (avail != 5'd0) begin
                        dsz           = disp_size(byte0);
                        rec_n.modrm   = byte0;
                        rec_n.disp_sz = dsz;
                        pc_n          = pc_q + 16'd1;
                        end_n         = end_q + 16'd1;
                        state_n = (({1'b0, dsz} + rec_q.imm_sz) == 3'd0) ? ST_TERMINAL : ST_OPERANDS;
                    end
                end
                ST_OPERANDS: begin
                    rem = {3'b0, rec_q.disp_sz} + {2'b0, rec_q.imm_sz} - {2'b0, rec_q.opnd_cnt};
                    n   = 5'(BYTES_PER_CYCLE);
                    if (avail < n) n = avail;
                    if (rem < n)   n = rem;
                    // Disp bytes fill first, then imm; one cycle may cover both.
                    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
                        if (k < int'(n)) begin
                            bidx  = {1'b0, rec_q.opnd_cnt} + 4'(k);
                            qaddr = pc_q + 16'(k);
                            qbyte = ipq[qaddr[QW-1:0]];
                            if (bidx < {2'b00, rec_q.disp_sz}) begin
                                rec_n.disp[{bidx[0], 3'b000} +: 8] = qbyte;
                            end else begin
                                iidx = 2'(bidx - {2'b00, rec_q.disp_sz});
                                rec_n.imm[{iidx, 3'b000} +: 8] = qbyte;
                            end
                        end
                    end
                    rec_n.opnd_cnt = rec_q.opnd_cnt + n[2:0];
                    pc_n  = pc_q + {11'd0, n};
                    end_n = end_q + {11'd0, n};
                    if (n != 5'd0 && n == rem) state_n = ST_TERMINAL;
                end
                default: ;
            endcase

            if (take_op && avail != 5'd0) begin
                pc_n  = pc_q + 16'd1;
                end_n = end_q + 16'd1;
                if (cls_is_prefix) begin
                    if (rec_n.prefix_count < 4'(MAX_PREFIX)) begin
                        for (int i = 0; i < MAX_PREFIX; i++) begin
                            if (rec_n.prefix_count == 4'(i)) rec_n.prefixes[i] = byte0;
                        end
                        rec_n.prefix_count = rec_n.prefix_count + 4'd1;
                    end else begin
                        rec_n.prefix_ovf = 1'b1;
                    end
                end else begin
                    rec_n.opcode = byte0;
                    rec_n.imm_sz = imm_sz_in;
                    if (cls_has_modrm)           state_n = ST_MODRM;
                    else if (imm_sz_in == 3'd0)  state_n = ST_TERMINAL;
                    else                         state_n = ST_OPERANDS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_OPCODE;
            pc_q    <= 16'd0;
            start_q <= 16'd0;
            end_q   <= 16'd0;
            rec_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            start_q <= start_n;
            end_q   <= end_n;
            rec_q   <= rec_n;
        end
    end

    assign pc           = pc_q;
    assign valid        = (state_q == ST_TERMINAL) && !set_pc;
    assign start_pc     = start_q;
    assign end_pc       = end_q;
    assign length       = 4'(end_q - start_q);
    assign prefix_count = rec_q.prefix_count;
    assign prefixes     = rec_q.prefixes;
    assign prefix_ovf   = rec_q.prefix_ovf;
    assign opcode       = rec_q.opcode;
    assign modrm        = rec_q.modrm;
    assign disp         = rec_q.disp;
    assign imm          = rec_q.imm;

endmodule
